// File: rtl/herzel_pkg.sv
// Shared types and defaults for the Goertzel result buffer.
// Frame layout: frame number above NF signed result words.
package herzel_pkg;

  localparam int HRZ_NF    = 6;
  localparam int HRZ_DW    = 32;
  localparam int HRZ_DEPTH = 4;
  localparam int HRZ_FCW   = 16;

  typedef logic signed [HRZ_DW-1:0] hrz_word_t;

  typedef struct packed {
    logic [HRZ_FCW-1:0]         frame;
    hrz_word_t [HRZ_NF-1:0]     data;
  } hrz_frame_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Register FIFO of whole frames; one entry per committed frame.
// A write into a full FIFO is accepted only alongside a pop.
module frame_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  output logic          full,
  input  logic          rd_pop,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_rd   = rd_pop & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/herzel_result_buf.sv
// Captures per-bin Goertzel results into frames, buffers whole
// frames and streams them out one word per handshake.
module herzel_result_buf
  import herzel_pkg::*;
#(
  parameter  int NF    = HRZ_NF,
  parameter  int DW    = HRZ_DW,
  parameter  int DEPTH = HRZ_DEPTH,
  parameter  int FCW   = HRZ_FCW,
  localparam int IW    = idx_w(NF),
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear_i,
  input  logic [NF-1:0]  valid_i,
  input  logic [NF*DW-1:0] data_i,
  output logic           m_valid_o,
  input  logic           m_ready_i,
  output logic [DW-1:0]  m_data_o,
  output logic [IW-1:0]  m_idx_o,
  output logic           m_last_o,
  output logic [FCW-1:0] m_frame_o,
  output logic [CW-1:0]  frames_o,
  output logic           ovf_o,
  output logic [15:0]    ovf_cnt_o
);

  localparam int SW = NF*DW;
  localparam int EW = FCW + SW;

  logic [NF-1:0]  valid_prev;
  logic [NF-1:0]  mask;
  logic [NF-1:0]  rise;
  logic [SW-1:0]  stage;
  logic [FCW-1:0] frame_cnt;
  logic [IW-1:0]  widx;
  logic           complete;
  logic           pop;
  logic           last_pop;
  logic           room;
  logic           wr_en;
  logic           full;
  logic           empty;
  logic [EW-1:0]  rd_entry;
  logic [CW-1:0]  count;
  logic [DW-1:0]  word;

  assign rise     = valid_i & ~valid_prev;
  assign complete = &mask;
  assign m_valid_o = ~empty;
  assign pop      = m_valid_o & m_ready_i;
  assign last_pop = pop & (widx == IW'(NF-1));
  assign room     = ~full | last_pop;
  assign wr_en    = complete & room & ~clear_i;

  frame_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_i),
    .wr_en   (wr_en),
    .wr_data ({frame_cnt, stage}),
    .full    (full),
    .rd_pop  (last_pop),
    .rd_data (rd_entry),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
    end else if (!clear_i) begin
      for (int k = 0; k < NF; k++) begin
        if (rise[k]) begin
          stage[k*DW +: DW] <= data_i[k*DW +: DW];
        end
      end
    end
  end

  // A commit clears the mask in the same edge, so a rise then starts
  // the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_prev <= '0;
      mask       <= '0;
      frame_cnt  <= '0;
      widx       <= '0;
      ovf_o      <= 1'b0;
      ovf_cnt_o  <= '0;
    end else if (clear_i) begin
      valid_prev <= valid_i;
      mask       <= '0;
      frame_cnt  <= '0;
      widx       <= '0;
      ovf_o      <= 1'b0;
      ovf_cnt_o  <= '0;
    end else begin
      valid_prev <= valid_i;
      mask       <= (complete ? '0 : mask) | rise;
      if (complete) begin
        frame_cnt <= frame_cnt + FCW'(1);
        if (!room) begin
          ovf_o <= 1'b1;
          if (ovf_cnt_o != 16'hFFFF) begin
            ovf_cnt_o <= ovf_cnt_o + 16'd1;
          end
        end
      end
      if (pop) begin
        widx <= last_pop ? '0 : widx + IW'(1);
      end
    end
  end

  always_comb begin
    word = '0;
    for (int k = 0; k < NF; k++) begin
      if (widx == IW'(k)) begin
        word = rd_entry[k*DW +: DW];
      end
    end
  end

  assign m_data_o  = m_valid_o ? word : '0;
  assign m_idx_o   = widx;
  assign m_last_o  = m_valid_o & (widx == IW'(NF-1));
  assign m_frame_o = m_valid_o ? rd_entry[EW-1 -: FCW] : '0;
  assign frames_o  = count;

endmodule
